// File: rtl/iowrite_pkg.sv
// iowrite_pkg: shared constants for the LED / 7-segment output path.
//   - SEG_HEX_0..SEG_HEX_F : active-low cathode patterns {dp,g,f,e,d,c,b,a}, dp off
//   - SEG_BLANK            : all cathodes off
//   - AN_OFF               : all anodes off (8-digit board width)
package iowrite_pkg;

  localparam logic [7:0] SEG_HEX_0 = 8'hC0;
  localparam logic [7:0] SEG_HEX_1 = 8'hF9;
  localparam logic [7:0] SEG_HEX_2 = 8'hA4;
  localparam logic [7:0] SEG_HEX_3 = 8'hB0;
  localparam logic [7:0] SEG_HEX_4 = 8'h99;
  localparam logic [7:0] SEG_HEX_5 = 8'h92;
  localparam logic [7:0] SEG_HEX_6 = 8'h82;
  localparam logic [7:0] SEG_HEX_7 = 8'hF8;
  localparam logic [7:0] SEG_HEX_8 = 8'h80;
  localparam logic [7:0] SEG_HEX_9 = 8'h90;
  localparam logic [7:0] SEG_HEX_A = 8'h88;
  localparam logic [7:0] SEG_HEX_B = 8'h83;
  localparam logic [7:0] SEG_HEX_C = 8'hC6;
  localparam logic [7:0] SEG_HEX_D = 8'hA1;
  localparam logic [7:0] SEG_HEX_E = 8'h86;
  localparam logic [7:0] SEG_HEX_F = 8'h8E;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

endpackage

// File: rtl/seg_hex_decoder.sv
// seg_hex_decoder: combinational hex nibble to 7-segment cathode pattern.
// Ports:
//   nibble_i [3:0] : value to display
//   cat_o    [7:0] : active-low cathodes {dp,g,f,e,d,c,b,a}; dp always off
module seg_hex_decoder
  import iowrite_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] cat_o
);

  always_comb begin
    cat_o = SEG_BLANK;
    case (nibble_i)
      4'h0: cat_o = SEG_HEX_0;
      4'h1: cat_o = SEG_HEX_1;
      4'h2: cat_o = SEG_HEX_2;
      4'h3: cat_o = SEG_HEX_3;
      4'h4: cat_o = SEG_HEX_4;
      4'h5: cat_o = SEG_HEX_5;
      4'h6: cat_o = SEG_HEX_6;
      4'h7: cat_o = SEG_HEX_7;
      4'h8: cat_o = SEG_HEX_8;
      4'h9: cat_o = SEG_HEX_9;
      4'hA: cat_o = SEG_HEX_A;
      4'hB: cat_o = SEG_HEX_B;
      4'hC: cat_o = SEG_HEX_C;
      4'hD: cat_o = SEG_HEX_D;
      4'hE: cat_o = SEG_HEX_E;
      4'hF: cat_o = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/iowrite_ctrl.sv
// iowrite_ctrl: output-side I/O controller. Holds the LED register and the
// 32-bit segment register written by store-word I/O cycles, and scans the
// multiplexed 7-segment display with a prescaled digit counter.
// Parameters:
//   SCAN_DIV   : clocks each digit stays lit (>= 2)
//   NUM_DIGITS : number of display digits (8 on the board, <= 8)
// Ports:
//   clock, reset_n       : system clock, asynchronous active-low reset
//   iow                  : I/O write strobe
//   ledctrl, segctrl     : chip selects for LED / segment registers
//   addr_hi              : segment half select (0 = digits 3..0, 1 = 7..4)
//   iowrite_data [15:0]  : write data
//   led_out [15:0]       : LED drive, 1 = lit
//   seg_an               : digit anodes, active-low
//   seg_cat [7:0]        : cathodes {dp,g,f,e,d,c,b,a}, active-low
//   write_ack            : one-cycle pulse after each accepted write
//   readback_data [15:0] : LED register, only when IOWRITE_READBACK_EN is defined
module iowrite_ctrl
  import iowrite_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter int NUM_DIGITS = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  iow,
  input  logic                  ledctrl,
  input  logic                  segctrl,
  input  logic                  addr_hi,
  input  logic [15:0]           iowrite_data,
  output logic [15:0]           led_out,
  output logic [NUM_DIGITS-1:0] seg_an,
  output logic [7:0]            seg_cat,
  output logic                  write_ack
`ifdef IOWRITE_READBACK_EN
  ,
  output logic [15:0]           readback_data
`endif
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0]         PRESC_TC = PW'(SCAN_DIV - 1);
  localparam logic [DW-1:0]         DIG_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_BLANK = {NUM_DIGITS{AN_OFF[0]}};
  localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

  logic [15:0]           led_q, led_d;
  logic [31:0]           seg_q, seg_d;
  logic                  ack_q, ack_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [DW-1:0]         digit_q, digit_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            cat_q, cat_d;

  logic [3:0] nibble;
  logic [7:0] cat_dec;

  // Write path: chip selects only count while iow is high; a dual select
  // updates both registers from the same data and still acks once.
  always_comb begin
    led_d = led_q;
    seg_d = seg_q;
    ack_d = 1'b0;
    if (iow) begin
      if (ledctrl) led_d = iowrite_data;
      if (segctrl) begin
        if (addr_hi) seg_d[31:16] = iowrite_data;
        else         seg_d[15:0]  = iowrite_data;
      end
      ack_d = ledctrl | segctrl;
    end
  end

  // Scan: prescaler terminal count advances the digit index.
  always_comb begin
    presc_d = presc_q + PW'(1);
    digit_d = digit_q;
    if (presc_q == PRESC_TC) begin
      presc_d = '0;
      digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + DW'(1);
    end
  end

  // Nibble is taken straight from seg_q so a write to the lit digit shows
  // up on the next output register update.
  always_comb begin
    nibble = seg_q[4*int'(digit_q) +: 4];
  end

  seg_hex_decoder u_dec (
    .nibble_i (nibble),
    .cat_o    (cat_dec)
  );

  always_comb begin
    an_d  = ~(AN_ONE << digit_q);
    cat_d = cat_dec;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      led_q   <= '0;
      seg_q   <= '0;
      ack_q   <= 1'b0;
      presc_q <= '0;
      digit_q <= '0;
      an_q    <= AN_BLANK;
      cat_q   <= SEG_BLANK;
    end else begin
      led_q   <= led_d;
      seg_q   <= seg_d;
      ack_q   <= ack_d;
      presc_q <= presc_d;
      digit_q <= digit_d;
      an_q    <= an_d;
      cat_q   <= cat_d;
    end
  end

  assign led_out   = led_q;
  assign seg_an    = an_q;
  assign seg_cat   = cat_q;
  assign write_ack = ack_q;

`ifdef IOWRITE_READBACK_EN
  assign readback_data = led_q;
`endif

endmodule

// File: tb/tb_iowrite_ctrl.sv
// tb_iowrite_ctrl: scoreboard bench for iowrite_ctrl (SCAN_DIV=4, 8 digits).
// Expectations are queued with the cycle they fall due and compared on the
// falling edge of that cycle. Build with IOWRITE_READBACK_EN to cover readback.
module tb_iowrite_ctrl;

  localparam int S = 4;
  localparam int N = 8;

  localparam int K_LED = 0;
  localparam int K_ACK = 1;
  localparam int K_AN  = 2;
  localparam int K_CAT = 3;
  localparam int K_RB  = 4;

  typedef struct {
    int          kind;
    int          due;
    logic [15:0] val;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        iow = 1'b0;
  logic        ledctrl = 1'b0;
  logic        segctrl = 1'b0;
  logic        addr_hi = 1'b0;
  logic [15:0] iowrite_data = 16'h0;
  logic [15:0] led_out;
  logic [N-1:0] seg_an;
  logic [7:0]  seg_cat;
  logic        write_ack;
`ifdef IOWRITE_READBACK_EN
  logic [15:0] readback_data;
`endif

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  int rel_cyc = 0;

  logic [15:0] led_model = 16'h0;
  logic [31:0] seg_model = 32'h0;
  exp_t sb[$];

  logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  iowrite_ctrl #(.SCAN_DIV(S), .NUM_DIGITS(N)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .iow          (iow),
    .ledctrl      (ledctrl),
    .segctrl      (segctrl),
    .addr_hi      (addr_hi),
    .iowrite_data (iowrite_data),
    .led_out      (led_out),
    .seg_an       (seg_an),
    .seg_cat      (seg_cat),
    .write_ack    (write_ack)
`ifdef IOWRITE_READBACK_EN
    ,
    .readback_data (readback_data)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h want %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic string tag_of(input int kind);
    case (kind)
      K_LED:   return "led_out";
      K_ACK:   return "write_ack";
      K_AN:    return "seg_an";
      K_CAT:   return "seg_cat";
      default: return "readback";
    endcase
  endfunction

  function automatic logic [15:0] observe(input int kind);
    case (kind)
      K_LED:   return led_out;
      K_ACK:   return {15'b0, write_ack};
      K_AN:    return {8'b0, seg_an};
      K_CAT:   return {8'b0, seg_cat};
`ifdef IOWRITE_READBACK_EN
      K_RB:    return readback_data;
`endif
      default: return 16'hxxxx;
    endcase
  endfunction

  always @(negedge clock) begin : monitor
    exp_t keep[$];
    keep.delete();
    foreach (sb[i]) begin
      if (sb[i].due == cyc) check_val(tag_of(sb[i].kind), observe(sb[i].kind), sb[i].val);
      else                  keep.push_back(sb[i]);
    end
    sb = keep;
  end

  // One stimulus cycle: drive inputs, update the model, queue LED/ack results.
  task automatic step(input logic w, input logic l, input logic s, input logic h,
                      input logic [15:0] d);
    @(negedge clock);
    iow = w; ledctrl = l; segctrl = s; addr_hi = h; iowrite_data = d;
    if (w && l) led_model = d;
    if (w && s) begin
      if (h) seg_model[31:16] = d;
      else   seg_model[15:0]  = d;
    end
    sb.push_back('{kind: K_LED, due: cyc + 1, val: led_model});
    sb.push_back('{kind: K_ACK, due: cyc + 1, val: {15'b0, w & (l | s)}});
`ifdef IOWRITE_READBACK_EN
    sb.push_back('{kind: K_RB, due: cyc + 1, val: led_model});
`endif
  endtask

  // Queue anode/cathode expectations for the next ncyc cycles, counting
  // digit periods from the reset release cycle.
  task automatic push_scan(input int ncyc);
    for (int k = 1; k <= ncyc; k++) begin
      int t;
      int dig;
      logic [7:0] an;
      logic [3:0] nib;
      t   = cyc + k;
      dig = ((t - rel_cyc - 1) / S) % N;
      an  = ~(8'b1 << dig);
      nib = seg_model[4*dig +: 4];
      sb.push_back('{kind: K_AN,  due: t, val: {8'b0, an}});
      sb.push_back('{kind: K_CAT, due: t, val: {8'b0, hex_tbl[nib]}});
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) begin
      @(negedge clock);
      #1;
    end
    check_val("drain", 16'(sb.size()), 16'd0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_led"}, led_out, 16'h0000);
    check_val({pfx, "_an"},  {8'b0, seg_an}, 16'h00FF);
    check_val({pfx, "_cat"}, {8'b0, seg_cat}, 16'h00FF);
    check_val({pfx, "_ack"}, {15'b0, write_ack}, 16'h0000);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    #1;
    check_reset_outputs("rst0");

    @(negedge clock);
    reset_n = 1'b1;
    rel_cyc = cyc;
    push_scan(N * S + 2);
    wait_drain(200);

    // LED write, then a cycle with iow low that must be ignored
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'hA5C3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    wait_drain(20);

    // back-to-back segment writes, both halves
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h3210);
    step(1'b1, 1'b0, 1'b1, 1'b1, 16'hFEDC);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    push_scan(N * S);
    wait_drain(200);

    // both chip selects at once
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0009);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    push_scan(N * S);
    wait_drain(200);

    // long run across several wraps
    push_scan(33 * S);
    wait_drain(400);

`ifdef IOWRITE_READBACK_EN
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h1234);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    wait_drain(20);
`endif

    // asynchronous reset in the middle of a digit period
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    led_model = 16'h0;
    seg_model = 32'h0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    rel_cyc = cyc;
    push_scan(2 * S + 1);
    wait_drain(100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

endmodule
